// File: rtl/mole_pkg.sv
// Shared types for the whack-a-mole round scheduler.
// Holds the state encoding, LFSR taps and the index-width helper.
package mole_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GAP,
        S_PICK,
        S_UP,
        S_DONE
    } state_e;

    // Fibonacci taps 16,14,13,11 as a mask over value[15:0]
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mole_lfsr.sv
// 16-bit Fibonacci LFSR used to pick which mole rises next.
// Ports: clk, clr_n (sync, active-low), step (advance), value (state).
module mole_lfsr
    import mole_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        step,
    output logic [15:0] value
);

    logic [15:0] value_q;
    logic [15:0] value_d;

    always_comb begin
        value_d = value_q;
        if (step) begin
            value_d = {value_q[14:0], ^(value_q & LFSR_TAPS)};
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            value_q <= SEED;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/mole_toggle_sched.sv
// Round scheduler driving a bank of toggle flip-flops (one per mole).
// In: clk, clr_n, start, stop, hit_valid, hit_idx. Out: ff_clr, tog_en,
// mole_up (bank shadow), score, misses, busy, done.
module mole_toggle_sched
    import mole_pkg::*;
#(
    parameter int          N_MOLES    = 8,
    parameter int          UP_CYCLES  = 1024,
    parameter int          GAP_CYCLES = 256,
    parameter int          ROUNDS     = 16,
    parameter int          SCORE_W    = 8,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                        clk,
    input  logic                        clr_n,
    input  logic                        start,
    input  logic                        stop,
    input  logic                        hit_valid,
    input  logic [idx_w(N_MOLES)-1:0]   hit_idx,
    output logic                        ff_clr,
    output logic [N_MOLES-1:0]          tog_en,
    output logic [N_MOLES-1:0]          mole_up,
    output logic [SCORE_W-1:0]          score,
    output logic [SCORE_W-1:0]          misses,
    output logic                        busy,
    output logic                        done
);

    localparam int IW   = idx_w(N_MOLES);
    localparam int CMAX = (UP_CYCLES > GAP_CYCLES) ? UP_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(CMAX);
    localparam int RW   = $clog2(ROUNDS + 1);

    localparam logic [CW-1:0] UP_LOAD  = CW'(UP_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 1);
    localparam logic [RW-1:0] LAST_RND = RW'(ROUNDS);

    function automatic logic [N_MOLES-1:0] onehot(input logic [IW-1:0] i);
        return {{(N_MOLES-1){1'b0}}, 1'b1} << i;
    endfunction

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [RW-1:0]        rnd_q, rnd_d;
    logic [IW-1:0]        cur_q, cur_d;
    logic                 ff_clr_q, ff_clr_d;
    logic [N_MOLES-1:0]   tog_q, tog_d;
    logic [N_MOLES-1:0]   up_q, up_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [SCORE_W-1:0]   miss_q, miss_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 lfsr_step;
    logic                 lower;
    logic [15:0]          lfsr_val;
    logic                 unused_lfsr;

    mole_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .clr_n (clr_n),
        .step  (lfsr_step),
        .value (lfsr_val)
    );

    // only the low index bits pick a mole
    assign unused_lfsr = ^lfsr_val[15:IW];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rnd_d     = rnd_q;
        cur_d     = cur_q;
        ff_clr_d  = 1'b0;
        tog_d     = '0;
        // shadow flips on the same edge the bank samples its enable
        up_d      = up_q ^ tog_q;
        score_d   = score_q;
        miss_d    = miss_q;
        done_d    = 1'b0;
        lfsr_step = 1'b0;
        lower     = 1'b0;

        if (stop) begin
            // a mole that is (or is just becoming) up gets lowered
            if (state_q == S_UP && up_d[cur_q]) begin
                tog_d = onehot(cur_q);
            end
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        score_d  = '0;
                        miss_d   = '0;
                        rnd_d    = '0;
                        up_d     = '0;
                        ff_clr_d = 1'b1;
                        cnt_d    = GAP_LOAD;
                        state_d  = S_GAP;
                    end
                end
                S_GAP: begin
                    if (cnt_q == '0) begin
                        state_d = S_PICK;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                S_PICK: begin
                    cur_d     = lfsr_val[IW-1:0];
                    lfsr_step = 1'b1;
                    tog_d     = onehot(cur_d);
                    cnt_d     = UP_LOAD;
                    state_d   = S_UP;
                end
                S_UP: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CW'(1);
                    end
                    // a hit on the timeout cycle counts as a hit
                    if (hit_valid && hit_idx == cur_q && up_q[cur_q]) begin
                        lower = 1'b1;
                        if (score_q != '1) begin
                            score_d = score_q + SCORE_W'(1);
                        end
                    end else if (cnt_q == '0) begin
                        lower = 1'b1;
                        if (miss_q != '1) begin
                            miss_d = miss_q + SCORE_W'(1);
                        end
                    end
                    if (lower) begin
                        tog_d = onehot(cur_q);
                        rnd_d = rnd_q + RW'(1);
                        if (rnd_d == LAST_RND) begin
                            done_d  = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            cnt_d   = GAP_LOAD;
                            state_d = S_GAP;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        busy_d = (state_d == S_GAP) || (state_d == S_PICK) ||
                 (state_d == S_UP);
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rnd_q    <= '0;
            cur_q    <= '0;
            ff_clr_q <= 1'b1;
            tog_q    <= '0;
            up_q     <= '0;
            score_q  <= '0;
            miss_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rnd_q    <= rnd_d;
            cur_q    <= cur_d;
            ff_clr_q <= ff_clr_d;
            tog_q    <= tog_d;
            up_q     <= up_d;
            score_q  <= score_d;
            miss_q   <= miss_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign ff_clr  = ff_clr_q;
    assign tog_en  = tog_q;
    assign mole_up = up_q;
    assign score   = score_q;
    assign misses  = miss_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_mole_toggle_sched.sv
// Bench for mole_toggle_sched: game-level model plus directed games.
// A second instance with 300 rounds exercises score saturation.
module tb_mole_toggle_sched;

    localparam int UP  = 4;
    localparam int GAP = 2;
    localparam int RND = 3;

    localparam int P_IDLE = 0;
    localparam int P_GAP  = 1;
    localparam int P_PICK = 2;
    localparam int P_UP   = 3;
    localparam int P_DONE = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       clr_n, start, stop, hit_valid;
    logic [1:0] hit_idx;
    logic       ff_clr, busy, done;
    logic [3:0] tog_en, mole_up;
    logic [7:0] score, misses;

    logic       start2, stop2, hv2;
    logic [1:0] hi2;
    logic       ff_clr2, busy2, done2;
    logic [3:0] tog2, up2;
    logic [7:0] score2, miss2;

    int checks = 0;
    int errors = 0;

    mole_toggle_sched #(
        .N_MOLES(4), .UP_CYCLES(UP), .GAP_CYCLES(GAP),
        .ROUNDS(RND), .SCORE_W(8), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .clr_n(clr_n), .start(start), .stop(stop),
        .hit_valid(hit_valid), .hit_idx(hit_idx), .ff_clr(ff_clr),
        .tog_en(tog_en), .mole_up(mole_up), .score(score),
        .misses(misses), .busy(busy), .done(done)
    );

    mole_toggle_sched #(
        .N_MOLES(4), .UP_CYCLES(4), .GAP_CYCLES(1),
        .ROUNDS(300), .SCORE_W(8), .LFSR_SEED(16'hACE1)
    ) dut2 (
        .clk(clk), .clr_n(clr_n), .start(start2), .stop(stop2),
        .hit_valid(hv2), .hit_idx(hi2), .ff_clr(ff_clr2),
        .tog_en(tog2), .mole_up(up2), .score(score2),
        .misses(miss2), .busy(busy2), .done(done2)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [3:0] oh(input logic [1:0] i);
        logic [3:0] v;
        v = 4'd1;
        return v << i;
    endfunction

    function automatic logic [1:0] enc(input logic [3:0] v);
        if (v[3]) return 2'd3;
        if (v[2]) return 2'd2;
        if (v[1]) return 2'd1;
        return 2'd0;
    endfunction

    // x^16 + x^14 + x^13 + x^11 + 1, shifting toward the MSB
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[16-1] ^ s[14-1] ^ s[13-1] ^ s[11-1]};
    endfunction

    // ---------------- game-level model ----------------
    int         ph = P_IDLE;
    int         t = 0;
    int         rnd = 0;
    int         e_score = 0;
    int         e_miss = 0;
    logic [1:0] cur = 2'd0;
    logic [15:0] lfsr = 16'hACE1;
    logic       e_ffclr = 1'b1;
    logic [3:0] e_tog = 4'd0;
    logic [3:0] e_up = 4'd0;
    logic       e_busy = 1'b0;
    logic       e_done = 1'b0;
    bit         m_valid = 0;

    always @(posedge clk) begin
        logic [3:0] bank;
        logic [3:0] pulse;
        bit lowered;
        m_valid = 1;
        if (!clr_n) begin
            ph = P_IDLE; t = 0; rnd = 0; e_score = 0; e_miss = 0;
            lfsr = 16'hACE1; e_ffclr = 1'b1; e_tog = 4'd0;
            e_up = 4'd0; e_busy = 1'b0; e_done = 1'b0;
        end else begin
            bank = e_up ^ e_tog;
            pulse = 4'd0;
            lowered = 0;
            e_done = 1'b0;
            e_ffclr = 1'b0;
            if (stop) begin
                if (ph == P_UP && bank[cur]) pulse = oh(cur);
                ph = P_IDLE;
            end else if (ph == P_IDLE || ph == P_DONE) begin
                if (start) begin
                    e_score = 0; e_miss = 0; rnd = 0; bank = 4'd0;
                    e_ffclr = 1'b1; t = 0; ph = P_GAP;
                end
            end else if (ph == P_GAP) begin
                t++;
                if (t >= GAP) ph = P_PICK;
            end else if (ph == P_PICK) begin
                cur = lfsr[1:0];
                lfsr = lfsr_next(lfsr);
                pulse = oh(cur);
                t = 0;
                ph = P_UP;
            end else begin
                t++;
                if (hit_valid && hit_idx == cur && e_up[cur]) begin
                    lowered = 1;
                    if (e_score < 255) e_score++;
                end else if (t == UP) begin
                    lowered = 1;
                    if (e_miss < 255) e_miss++;
                end
                if (lowered) begin
                    pulse = oh(cur);
                    rnd++;
                    if (rnd == RND) begin
                        ph = P_DONE;
                        e_done = 1'b1;
                    end else begin
                        ph = P_GAP;
                        t = 0;
                    end
                end
            end
            e_up = bank;
            e_tog = pulse;
            e_busy = (ph == P_GAP || ph == P_PICK || ph == P_UP);
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("ff_clr", ff_clr, e_ffclr);
            chk("tog_en", tog_en, e_tog);
            chk("mole_up", mole_up, e_up);
            chk("score", score, e_score);
            chk("misses", misses, e_miss);
            chk("busy", busy, e_busy);
            chk("done", done, e_done);
            chk("tog_onehot0", ($countones(tog_en) <= 1), 1);
        end
    end

    // per-game tallies of the DUT outputs
    bit         tally_on = 0;
    int         n_tog = 0;
    int         n_upc = 0;
    int         n_done = 0;
    logic [3:0] first_tog = 4'd0;

    always @(negedge clk) begin
        if (tally_on) begin
            if (tog_en != 4'd0) n_tog++;
            if (tog_en != 4'd0 && first_tog == 4'd0) first_tog = tog_en;
            if (mole_up != 4'd0) n_upc++;
            if (done) n_done++;
        end
    end

    task automatic tally_clr();
        n_tog = 0; n_upc = 0; n_done = 0; first_tog = 4'd0;
        tally_on = 1;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_raise();
        int n;
        n = 0;
        while (e_up != 4'd0 && n < 50) begin @(negedge clk); n++; end
        while (e_up == 4'd0 && n < 50) begin @(negedge clk); n++; end
        chk("raise_timeout", (n < 50), 1);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (ph != P_DONE && n < 200) begin @(negedge clk); n++; end
        chk("done_timeout", (n < 200), 1);
    endtask

    task automatic strike(input logic [1:0] idx);
        hit_valid = 1'b1;
        hit_idx = idx;
        @(negedge clk);
        hit_valid = 1'b0;
        chk("lower_after_hit", tog_en, oh(idx));
    endtask

    initial begin
        clr_n = 1'b0; start = 1'b0; stop = 1'b0;
        hit_valid = 1'b0; hit_idx = 2'd0;
        start2 = 1'b0; stop2 = 1'b0; hv2 = 1'b0; hi2 = 2'd0;

        // reset and idle
        repeat (3) @(negedge clk);
        chk("rst_ff_clr", ff_clr, 1);
        chk("rst_busy", busy, 0);
        chk("rst_tog", tog_en, 0);
        clr_n = 1'b1;
        @(negedge clk);
        chk("ff_clr_release", ff_clr, 0);
        cyc(10);
        chk("idle_score", score, 0);
        chk("idle_busy", busy, 0);

        // game 1: no hits, all three moles time out
        tally_clr();
        pulse_start();
        wait_done();
        cyc(2);
        chk("g1_pulses", n_tog, 6);
        chk("g1_up_cycles", n_upc, 12);
        chk("g1_done_cnt", n_done, 1);
        chk("g1_first_mole", first_tog, 4'b0010);
        chk("g1_misses", misses, 3);
        chk("g1_score", score, 0);

        // game 2: hit every mole one cycle after it rises
        tally_clr();
        pulse_start();
        for (int r = 0; r < 3; r++) begin
            wait_raise();
            strike(cur);
        end
        wait_done();
        cyc(2);
        chk("g2_first_mole", first_tog, 4'b1000);
        chk("g2_score", score, 3);
        chk("g2_misses", misses, 0);
        tally_on = 0;

        // game 3: wrong index, then correct hit on the timeout cycle
        pulse_start();
        wait_raise();
        hit_valid = 1'b1;
        hit_idx = cur ^ 2'd1;
        @(negedge clk);
        hit_valid = 1'b0;
        chk("wrong_idx_ignored", tog_en, 0);
        @(negedge clk);
        hit_valid = 1'b1;
        hit_idx = cur;
        @(negedge clk);
        hit_valid = 1'b0;
        chk("timeout_hit_lower", tog_en, oh(cur));
        chk("timeout_hit_score", score, 1);
        chk("timeout_hit_miss", misses, 0);
        wait_done();
        cyc(2);
        chk("g3_score", score, 1);
        chk("g3_misses", misses, 2);

        // game 4: one hit, then stop while the next mole is up
        pulse_start();
        wait_raise();
        strike(cur);
        wait_raise();
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("stop_lower", tog_en, oh(cur));
        chk("stop_busy", busy, 0);
        @(negedge clk);
        chk("stop_mole_up", mole_up, 0);
        chk("stop_score", score, 1);
        cyc(3);
        chk("stop_quiet", tog_en, 0);

        // game 5: restart clears counters, then reset lands mid-round
        pulse_start();
        chk("restart_score", score, 0);
        chk("restart_ff_clr", ff_clr, 1);
        wait_raise();
        @(negedge clk);
        clr_n = 1'b0;
        @(negedge clk);
        chk("midrst_ff_clr", ff_clr, 1);
        chk("midrst_tog", tog_en, 0);
        chk("midrst_up", mole_up, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        clr_n = 1'b1;
        cyc(3);

        // 300-round instance: every mole hit, score saturates
        begin : sat
            int n;
            bit seen;
            n = 0;
            seen = 0;
            start2 = 1'b1;
            @(negedge clk);
            start2 = 1'b0;
            while (!seen && n < 6000) begin
                hv2 = (up2 != 4'd0);
                hi2 = enc(up2);
                @(negedge clk);
                n++;
                if (done2) seen = 1;
            end
            hv2 = 1'b0;
            chk("sat_done_seen", seen, 1);
            chk("sat_score", score2, 255);
            chk("sat_misses", miss2, 0);
        end

        cyc(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
